// File: rtl/wb_regfile_stage.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file with two
// combinational read ports, sticky halt/program-status tracking and retire counter.
module wb_regfile_stage #(
  parameter logic [2:0]  STAT_AOK = 3'd0,
  parameter logic [2:0]  STAT_HLT = 3'd1,
  parameter logic [2:0]  STAT_ADR = 3'd2,
  parameter logic [2:0]  STAT_INS = 3'd3,
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       MM_icode,
  input  logic [63:0]      MM_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       MM_dstE,
  input  logic [3:0]       MM_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic             halted,
  output logic [2:0]       prog_stat,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_RSP   = 4'd4;

  logic [2:0]       r_w_stat;
  logic [3:0]       r_w_icode;
  logic [63:0]      r_w_valE;
  logic [63:0]      r_w_valM;
  logic [3:0]       r_w_dstE;
  logic [3:0]       r_w_dstM;
  logic             r_halted;
  logic [2:0]       r_prog_stat;
  logic [CNT_W-1:0] r_retired;
  logic [63:0]      r_regs [0:14];

  logic w_fault;
  logic w_commit;
  logic w_count;

  // Classify the status currently in W; any code other than AOK stops the machine.
  always_comb begin
    w_fault = 1'b0;
    case (r_w_stat)
      STAT_AOK: w_fault = 1'b0;
      STAT_HLT, STAT_ADR, STAT_INS: w_fault = 1'b1;
      default:  w_fault = 1'b1;
    endcase
  end

  assign w_commit = !w_fault && !r_halted;
  assign w_count  = w_commit && (r_w_icode != ICODE_NOP);

  // W pipeline register: reset > halted hold > stall hold > bubble > load.
  always_ff @(posedge clk) begin
    if (reset || (!r_halted && !W_stall && W_bubble)) begin
      r_w_stat  <= STAT_AOK;
      r_w_icode <= ICODE_NOP;
      r_w_valE  <= 64'h0;
      r_w_valM  <= 64'h0;
      r_w_dstE  <= REG_NONE;
      r_w_dstM  <= REG_NONE;
    end else if (r_halted || W_stall) begin
      r_w_stat  <= r_w_stat;
      r_w_icode <= r_w_icode;
      r_w_valE  <= r_w_valE;
      r_w_valM  <= r_w_valM;
      r_w_dstE  <= r_w_dstE;
      r_w_dstM  <= r_w_dstM;
    end else begin
      r_w_stat  <= m_stat;
      r_w_icode <= MM_icode;
      r_w_valE  <= MM_valE;
      r_w_valM  <= m_valM;
      r_w_dstE  <= MM_dstE;
      r_w_dstM  <= MM_dstM;
    end
  end

  // Register file commit; valM takes precedence when both dsts name the same register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      if (reset) begin
        r_regs[i] <= (4'(i) == REG_RSP) ? RSP_INIT : 64'h0;
      end else if (w_commit && (r_w_dstM == 4'(i))) begin
        r_regs[i] <= r_w_valM;
      end else if (w_commit && (r_w_dstE == 4'(i))) begin
        r_regs[i] <= r_w_valE;
      end else begin
        r_regs[i] <= r_regs[i];
      end
    end
  end

  // Sticky halt capture and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halted    <= 1'b0;
      r_prog_stat <= STAT_AOK;
      r_retired   <= '0;
    end else begin
      if (!r_halted && w_fault) begin
        r_halted    <= 1'b1;
        r_prog_stat <= r_w_stat;
      end else begin
        r_halted    <= r_halted;
        r_prog_stat <= r_prog_stat;
      end
      if (w_count) begin
        r_retired <= r_retired + CNT_W'(1);
      end else begin
        r_retired <= r_retired;
      end
    end
  end

  // Decode read ports; no write-to-read bypass, forwarding uses the W outputs.
  always_comb begin
    d_rvalA = 64'h0;
    d_rvalB = 64'h0;
    if (d_srcA != REG_NONE) begin
      d_rvalA = r_regs[d_srcA];
    end else begin
      d_rvalA = 64'h0;
    end
    if (d_srcB != REG_NONE) begin
      d_rvalB = r_regs[d_srcB];
    end else begin
      d_rvalB = 64'h0;
    end
  end

  assign W_stat    = r_w_stat;
  assign W_icode   = r_w_icode;
  assign W_valE    = r_w_valE;
  assign W_valM    = r_w_valM;
  assign W_dstE    = r_w_dstE;
  assign W_dstM    = r_w_dstM;
  assign halted    = r_halted;
  assign prog_stat = r_prog_stat;
  assign retired   = r_retired;

endmodule
